alu_share_arbiter: RTL and testbench

Shares the single 32-bit ALU (6-bit ALUControl, A, B, ALUResult, Zero) between two requesters, for example the EX-stage datapath and a branch-compare unit. It grants requests round-robin and holds the operands stable on the ALU for one cycle, or for MUL_LAT cycles on multiply (ALUControl 6'b011000). It then returns the registered result and Zero flag through a per-requester valid/ready response. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_share_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one ALU between two requesters,
// holding operands for one cycle (MUL_LAT cycles on multiply) and returning a registered result.
`timescale 1ns/1ps
module alu_share_arbiter #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid0,
  input  logic [5:0]  ReqOp0,
  input  logic [31:0] ReqA0,
  input  logic [31:0] ReqB0,
  output logic        ReqReady0,
  input  logic        ReqValid1,
  input  logic [5:0]  ReqOp1,
  input  logic [31:0] ReqA1,
  input  logic [31:0] ReqB1,
  output logic        ReqReady1,
  output logic [5:0]  AluControl,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  input  logic [31:0] AluResult,
  input  logic        AluZero,
  output logic        RspValid0,
  input  logic        RspReady0,
  output logic        RspValid1,
  input  logic        RspReady1,
  output logic [31:0] RspResult,
  output logic        RspZero
);

  localparam logic [5:0] MUL_OP  = 6'b011000;
  localparam logic [5:0] IDLE_OP = 6'b111111;
  localparam logic [3:0] CNT_MUL = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic        prio;
  logic        id;
  logic [3:0]  cnt;
  logic        grant1;
  logic        accept;
  logic        rsp_done;
  logic [5:0]  sel_op;
  logic [31:0] sel_a, sel_b;

  // Requester 1 wins when it is alone or when the pointer favours it.
  assign grant1    = ReqValid1 & (~ReqValid0 | prio);
  assign ReqReady0 = ~Rst & (state == IDLE) & ReqValid0 & ~grant1;
  assign ReqReady1 = ~Rst & (state == IDLE) & grant1;
  assign accept    = ReqReady0 | ReqReady1;
  assign rsp_done  = (state == RESP) & (id ? RspReady1 : RspReady0);

  assign sel_op = grant1 ? ReqOp1 : ReqOp0;
  assign sel_a  = grant1 ? ReqA1  : ReqA0;
  assign sel_b  = grant1 ? ReqB1  : ReqB0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = EXEC;
      EXEC:    if (cnt == '0)  state_nxt = RESP;
      RESP:    if (rsp_done)   state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      prio       <= 1'b0;
      id         <= 1'b0;
      cnt        <= '0;
      AluControl <= IDLE_OP;
      AluA       <= '0;
      AluB       <= '0;
      RspValid0  <= 1'b0;
      RspValid1  <= 1'b0;
      RspResult  <= '0;
      RspZero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            AluControl <= sel_op;
            AluA       <= sel_a;
            AluB       <= sel_b;
            id         <= grant1;
            cnt        <= (sel_op == MUL_OP) ? CNT_MUL : '0;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            RspResult  <= AluResult;
            RspZero    <= AluZero;
            AluControl <= IDLE_OP;
            if (id) RspValid1 <= 1'b1;
            else    RspValid0 <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_done) begin
            RspValid0 <= 1'b0;
            RspValid1 <= 1'b0;
            prio      <= ~id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

  localparam int unsigned MUL_LAT = 3;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_MUL  = 6'b011000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_UNDF = 6'b010101;
  localparam logic [5:0] OP_IDLE = 6'b111111;

  logic        Clk, Rst;
  logic        ReqValid0, ReqValid1, ReqReady0, ReqReady1;
  logic [5:0]  ReqOp0, ReqOp1, AluControl;
  logic [31:0] ReqA0, ReqB0, ReqA1, ReqB1, AluA, AluB, AluResult, RspResult;
  logic        AluZero, RspValid0, RspValid1, RspReady0, RspReady1, RspZero;

  int checks = 0;
  int failures = 0;

  alu_share_arbiter #(.MUL_LAT(MUL_LAT)) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqValid0(ReqValid0), .ReqOp0(ReqOp0), .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqReady0(ReqReady0),
    .ReqValid1(ReqValid1), .ReqOp1(ReqOp1), .ReqA1(ReqA1), .ReqB1(ReqB1), .ReqReady1(ReqReady1),
    .AluControl(AluControl), .AluA(AluA), .AluB(AluB), .AluResult(AluResult), .AluZero(AluZero),
    .RspValid0(RspValid0), .RspReady0(RspReady0), .RspValid1(RspValid1), .RspReady1(RspReady1),
    .RspResult(RspResult), .RspZero(RspZero)
  );

  // Stand-in for the shared ALU.
  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_MUL:  return a * b;
      OP_BEQ:  return a - b;
      OP_IDLE: return 32'h0;
      default: return a ^ b;
    endcase
  endfunction

  assign AluResult = alu_fn(AluControl, AluA, AluB);
  assign AluZero   = (AluResult == 32'h0);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        id;
    logic [5:0]  op;
    logic [31:0] a, b, res;
    logic        z;
    int          lat;
  } vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b;
  } req_t;

  logic [5:0] ops [0:6] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_BEQ, OP_UNDF};

  task automatic set_req(input logic id, input logic v, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (id) begin ReqValid1 = v; ReqOp1 = op; ReqA1 = a; ReqB1 = b; end
    else    begin ReqValid0 = v; ReqOp0 = op; ReqA0 = a; ReqB0 = b; end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    set_req(1'b0, 1'b0, 6'h0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 6'h0, 32'h0, 32'h0);
    RspReady0 = 1'b0; RspReady1 = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  // One complete transaction on an otherwise quiet bus.
  task automatic do_op(input vec_t v, input string nm);
    int n;
    @(negedge Clk);
    set_req(v.id, 1'b1, v.op, v.a, v.b);
    #1;
    check({nm, "_ready"},       32'(v.id ? ReqReady1 : ReqReady0), 32'd1);
    check({nm, "_ready_other"}, 32'(v.id ? ReqReady0 : ReqReady1), 32'd0);
    @(negedge Clk);
    set_req(v.id, 1'b0, 6'h0, 32'h0, 32'h0);
    #1;
    n = 0;
    while (!(RspValid0 | RspValid1) && n < 40) begin
      check({nm, "_exec_op"}, 32'(AluControl), 32'(v.op));
      check({nm, "_exec_a"},  AluA, v.a);
      check({nm, "_exec_b"},  AluB, v.b);
      @(negedge Clk); #1;
      n++;
    end
    check({nm, "_latency"},   32'(n), 32'(v.lat));
    check({nm, "_rsp_valid"}, 32'(v.id ? RspValid1 : RspValid0), 32'd1);
    check({nm, "_rsp_other"}, 32'(v.id ? RspValid0 : RspValid1), 32'd0);
    check({nm, "_result"},    RspResult, v.res);
    check({nm, "_zero"},      32'(RspZero), 32'(v.z));
    check({nm, "_alu_idle"},  32'(AluControl), 32'(OP_IDLE));
    if (v.id) RspReady1 = 1'b1; else RspReady0 = 1'b1;
    @(negedge Clk); #1;
    check({nm, "_rsp_clear"}, 32'(RspValid0 | RspValid1), 32'd0);
    RspReady0 = 1'b0; RspReady1 = 1'b0;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.op = ops[$urandom_range(0, 6)];
    r.a  = (r.op == OP_MUL) ? 32'($urandom_range(0, 65535)) : $urandom;
    r.b  = (r.op == OP_BEQ && $urandom_range(0, 1) == 1) ? r.a : $urandom;
    return r;
  endfunction

  // Transaction-level model: one op in flight, a due time for its response,
  // and a priority pointer flipped away from whoever was last served.
  task automatic random_test();
    req_t q0[$], q1[$], r;
    int now, due, busy, mprio;
    logic [5:0]  m_op;
    logic [31:0] m_a, m_b;
    logic er0, er1, ev0, ev1;
    for (int i = 0; i < 30; i++) begin
      q0.push_back(rand_req());
      q1.push_back(rand_req());
    end
    busy = -1; mprio = 0; now = 0; due = 0;
    m_op = OP_IDLE; m_a = '0; m_b = '0;
    while ((q0.size() > 0 || q1.size() > 0 || busy >= 0) && now < 5000) begin
      @(negedge Clk);
      ReqValid0 = (q0.size() > 0) && ($urandom_range(0, 3) != 0);
      if (q0.size() > 0) begin ReqOp0 = q0[0].op; ReqA0 = q0[0].a; ReqB0 = q0[0].b; end
      ReqValid1 = (q1.size() > 0) && ($urandom_range(0, 3) != 0);
      if (q1.size() > 0) begin ReqOp1 = q1[0].op; ReqA1 = q1[0].a; ReqB1 = q1[0].b; end
      RspReady0 = ($urandom_range(0, 2) == 0);
      RspReady1 = ($urandom_range(0, 2) == 0);
      #1;
      er0 = (busy < 0) && ReqValid0 && (!ReqValid1 || mprio == 0);
      er1 = (busy < 0) && ReqValid1 && !er0;
      ev0 = (busy == 0) && (now >= due);
      ev1 = (busy == 1) && (now >= due);
      check("rnd_ready0", 32'(ReqReady0), 32'(er0));
      check("rnd_ready1", 32'(ReqReady1), 32'(er1));
      check("rnd_rsp_valid0", 32'(RspValid0), 32'(ev0));
      check("rnd_rsp_valid1", 32'(RspValid1), 32'(ev1));
      if (busy >= 0 && now < due) begin
        check("rnd_exec_op", 32'(AluControl), 32'(m_op));
        check("rnd_exec_a", AluA, m_a);
        check("rnd_exec_b", AluB, m_b);
      end else begin
        check("rnd_alu_idle", 32'(AluControl), 32'(OP_IDLE));
      end
      if (ev0 || ev1) begin
        check("rnd_result", RspResult, alu_fn(m_op, m_a, m_b));
        check("rnd_zero", 32'(RspZero), 32'(alu_fn(m_op, m_a, m_b) == 32'h0));
      end
      if (er0 || er1) begin
        r = er0 ? q0.pop_front() : q1.pop_front();
        busy = er0 ? 0 : 1;
        m_op = r.op; m_a = r.a; m_b = r.b;
        due = now + ((r.op == OP_MUL) ? int'(MUL_LAT) : 1) + 1;
      end else if ((ev0 && RspReady0) || (ev1 && RspReady1)) begin
        mprio = 1 - busy;
        busy = -1;
      end
      now++;
    end
    check("rnd_drain", 32'(q0.size() + q1.size() + ((busy >= 0) ? 1 : 0)), 32'd0);
    RspReady0 = 1'b0; RspReady1 = 1'b0;
    set_req(1'b0, 1'b0, 6'h0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 6'h0, 32'h0, 32'h0);
  endtask

  initial begin
    vec_t vecs[8];
    int g, r, both, n;

    vecs[0] = '{id: 1'b0, op: OP_ADD,  a: 32'd5,        b: 32'd7,        res: 32'd12,       z: 1'b0, lat: 1};
    vecs[1] = '{id: 1'b1, op: OP_MUL,  a: 32'd6,        b: 32'd9,        res: 32'd54,       z: 1'b0, lat: 3};
    vecs[2] = '{id: 1'b0, op: OP_SUB,  a: 32'd10,       b: 32'd3,        res: 32'd7,        z: 1'b0, lat: 1};
    vecs[3] = '{id: 1'b1, op: OP_OR,   a: 32'hF0,       b: 32'h0F,       res: 32'hFF,       z: 1'b0, lat: 1};
    vecs[4] = '{id: 1'b0, op: OP_BEQ,  a: 32'h1234,     b: 32'h1234,     res: 32'h0,        z: 1'b1, lat: 1};
    vecs[5] = '{id: 1'b1, op: OP_BEQ,  a: 32'h1234,     b: 32'h1235,     res: 32'hFFFFFFFF, z: 1'b0, lat: 1};
    vecs[6] = '{id: 1'b0, op: OP_AND,  a: 32'hFF00FF00, b: 32'h0FF00FF0, res: 32'h0F000F00, z: 1'b0, lat: 1};
    vecs[7] = '{id: 1'b1, op: OP_UNDF, a: 32'd3,        b: 32'd5,        res: 32'd6,        z: 1'b0, lat: 1};

    Rst = 1'b1;
    set_req(1'b0, 1'b1, OP_ADD, 32'd1, 32'd2);
    set_req(1'b1, 1'b1, OP_ADD, 32'd3, 32'd4);
    RspReady0 = 1'b0; RspReady1 = 1'b0;
    #12;
    check("reset_ready0", 32'(ReqReady0), 32'd0);
    check("reset_ready1", 32'(ReqReady1), 32'd0);
    check("reset_alu_ctrl", 32'(AluControl), 32'(OP_IDLE));
    check("reset_alu_a", AluA, 32'h0);
    check("reset_alu_b", AluB, 32'h0);
    check("reset_rsp_valid", 32'({RspValid1, RspValid0}), 32'd0);
    check("reset_rsp_result", RspResult, 32'h0);
    check("reset_rsp_zero", 32'(RspZero), 32'd0);
    do_reset();

    for (int i = 0; i < 8; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Contention from reset: grants must alternate starting with requester 0.
    do_reset();
    @(negedge Clk);
    set_req(1'b0, 1'b1, OP_SUB, 32'd10, 32'd3);
    set_req(1'b1, 1'b1, OP_OR, 32'hF0, 32'h0F);
    RspReady0 = 1'b1; RspReady1 = 1'b1;
    g = 0; r = 0; both = 0;
    for (int c = 0; c < 40 && r < 4; c++) begin
      #1;
      if (ReqReady0 && ReqReady1) both++;
      if (ReqReady0 || ReqReady1) begin
        check("cont_grant_order", 32'(ReqReady1), 32'(g % 2));
        g++;
      end
      if (RspValid0 || RspValid1) begin
        check("cont_rsp_order", 32'(RspValid1), 32'(r % 2));
        check("cont_rsp_value", RspResult, RspValid1 ? 32'hFF : 32'd7);
        r++;
      end
      @(negedge Clk);
    end
    check("cont_never_both", 32'(both), 32'd0);
    check("cont_responses", 32'(r), 32'd4);

    // Backpressure on requester 0 while requester 1 waits.
    do_reset();
    @(negedge Clk);
    set_req(1'b0, 1'b1, OP_ADD, 32'd1, 32'd1);
    set_req(1'b1, 1'b1, OP_ADD, 32'd3, 32'd4);
    #1;
    check("bp_ready0", 32'(ReqReady0), 32'd1);
    check("bp_ready1_blocked", 32'(ReqReady1), 32'd0);
    @(negedge Clk);
    ReqValid0 = 1'b0;
    #1;
    check("bp_exec_ready1", 32'(ReqReady1), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk); #1;
      check("bp_hold_valid", 32'(RspValid0), 32'd1);
      check("bp_hold_result", RspResult, 32'd2);
      check("bp_hold_ready1", 32'(ReqReady1), 32'd0);
    end
    @(negedge Clk);
    RspReady0 = 1'b1;
    #1;
    check("bp_hs_valid", 32'(RspValid0), 32'd1);
    check("bp_hs_ready1", 32'(ReqReady1), 32'd0);
    @(negedge Clk);
    RspReady0 = 1'b0;
    #1;
    check("bp_after_valid", 32'(RspValid0), 32'd0);
    check("bp_after_ready1", 32'(ReqReady1), 32'd1);
    @(negedge Clk);
    ReqValid1 = 1'b0; RspReady1 = 1'b1;
    n = 0;
    #1;
    while (!RspValid1 && n < 20) begin @(negedge Clk); #1; n++; end
    check("bp_req1_valid", 32'(RspValid1), 32'd1);
    check("bp_req1_result", RspResult, 32'd7);
    @(negedge Clk);
    RspReady1 = 1'b0;

    // Reset during a multiply; the pointer was left favouring requester 1.
    do_op(vecs[0], "pre_rst");
    @(negedge Clk);
    set_req(1'b1, 1'b1, OP_MUL, 32'd6, 32'd9);
    #1;
    check("rstmul_ready1", 32'(ReqReady1), 32'd1);
    @(negedge Clk);
    ReqValid1 = 1'b0;
    @(negedge Clk);
    #1;
    check("rstmul_exec_a", AluA, 32'd6);
    ReqValid0 = 1'b1; ReqValid1 = 1'b1;
    Rst = 1'b1;
    #1;
    check("rstmul_ready0", 32'(ReqReady0), 32'd0);
    check("rstmul_ready1_low", 32'(ReqReady1), 32'd0);
    check("rstmul_alu_ctrl", 32'(AluControl), 32'(OP_IDLE));
    check("rstmul_alu_a", AluA, 32'h0);
    check("rstmul_alu_b", AluB, 32'h0);
    check("rstmul_rsp_valid", 32'({RspValid1, RspValid0}), 32'd0);
    check("rstmul_rsp_result", RspResult, 32'h0);
    check("rstmul_rsp_zero", 32'(RspZero), 32'd0);
    @(negedge Clk);
    ReqValid0 = 1'b0; ReqValid1 = 1'b0; RspReady0 = 1'b1; RspReady1 = 1'b1;
    Rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk); #1;
      check("rstmul_no_rsp", 32'(RspValid0 | RspValid1), 32'd0);
    end
    @(negedge Clk);
    ReqValid0 = 1'b1; ReqValid1 = 1'b1;
    #1;
    check("rstmul_first_grant0", 32'(ReqReady0), 32'd1);
    check("rstmul_first_grant1", 32'(ReqReady1), 32'd0);

    do_reset();
    random_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
